// File: rtl/kt8v_pkg.sv
// Shared definitions for the byte datapath feeding the 8-bit register stage.
package kt8v_pkg;

    // Byte width used throughout the datapath.
    localparam int DATA_W = 8;

    // Ceiling log2, usable in constant expressions for pointer and count widths.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/reg_load_fifo.sv
// Byte FIFO upstream of the 8-bit register stage. Bytes arrive over a
// valid/ready handshake and leave as one-cycle load strobes (out_en/out_data)
// wired straight onto the register's en/in pins. hold stalls the loads.
// Occupancy is tracked by an explicit counter, so full/empty never rely on
// pointer comparison. There is no empty bypass: minimum latency is two edges.
module reg_load_fifo
    import kt8v_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [WIDTH-1:0]        in_data,
    output logic                    in_ready,
    input  logic                    hold,
    output logic                    out_en,
    output logic [WIDTH-1:0]        out_data,
    output logic [clog2(DEPTH):0]   count
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    // Ready depends only on registered occupancy (and reset), never on in_valid or hold.
    assign in_ready = reset && (count != FULL_CNT);
    assign push     = in_valid && in_ready;
    assign pop      = (count != '0) && !hold;

    // Storage is deliberately not reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointer, occupancy and load-strobe state; reset discards everything queued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            out_en   <= 1'b0;
            out_data <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            // out_data keeps its last value on idle cycles; only out_en drops.
            out_en <= pop;
            if (pop) begin
                out_data <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_load_fifo.sv
// Scoreboard bench for reg_load_fifo: accepted bytes are queued as expected
// loads; a monitor pops and compares whenever out_en is presented.
module tb_reg_load_fifo;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       hold;
    logic       out_en;
    logic [7:0] out_data;
    logic [2:0] count;

    logic [7:0] reg_q;
    logic [7:0] exp_q[$];
    int         checks;
    int         errors;
    int         emitted;

    reg_load_fifo #(.WIDTH(8), .DEPTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .hold     (hold),
        .out_en   (out_en),
        .out_data (out_data),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Downstream register model: captures out_data on out_en.
    always @(posedge clk or negedge reset) begin
        if (!reset) reg_q <= 8'h00;
        else if (out_en) reg_q <= out_data;
    end

    // Stimulus side of the scoreboard: every accepted byte is an expected load.
    always @(posedge clk) begin
        if (reset === 1'b1 && in_valid === 1'b1 && in_ready === 1'b1)
            exp_q.push_back(in_data);
    end

    // Monitor: compare each presented load against the oldest expected byte.
    always @(negedge clk) begin
        if (reset === 1'b1 && out_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stream: got unexpected load %0h expected none", out_data);
            end else begin
                check("stream", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
                emitted++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int idx;
        int cyc;
        int maxc;
        checks   = 0;
        errors   = 0;
        emitted  = 0;
        reset    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hAA;
        hold     = 1'b0;

        // Reset with a byte offered: nothing may be taken.
        repeat (3) @(negedge clk);
        check("rst_count", count, 0);
        check("rst_out_en", out_en, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 0);
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_count", count, 0);
        check("post_rst_out_en", out_en, 0);

        // Single byte: push at edge 1, load strobe after edge 2, register after edge 3.
        in_valid = 1'b1;
        in_data  = 8'h0A;
        @(negedge clk);
        in_valid = 1'b0;
        check("single_e1_out_en", out_en, 0);
        check("single_e1_count", count, 1);
        @(negedge clk);
        check("single_e2_out_en", out_en, 1);
        check("single_e2_out_data", out_data, 8'h0A);
        @(negedge clk);
        check("single_e3_out_en", out_en, 0);
        check("single_e3_reg", reg_q, 8'h0A);
        check("single_hold_data", out_data, 8'h0A);

        // Fill with hold asserted; fifth byte must be refused.
        hold = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 5) begin
                check("fill_count4", count, 4);
                check("fill_in_ready", in_ready, 0);
            end
            in_valid = 1'b1;
            in_data  = 8'(i);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("full_count", count, 4);
        hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("drain_pulse", out_en, 1);
        end
        @(negedge clk);
        check("drain_out_en_end", out_en, 0);
        check("drain_count", count, 0);
        check("drain_queue", exp_q.size(), 0);

        // Wrap-around: 10 bytes, hold toggling every 3 cycles.
        emitted = 0;
        idx  = 0;
        maxc = 0;
        cyc  = 0;
        while ((idx < 10 || count != 0 || out_en) && cyc < 80) begin
            @(negedge clk);
            if (count > maxc) maxc = count;
            hold = ((cyc / 3) % 2) == 1;
            if (idx < 10) begin
                in_valid = 1'b1;
                in_data  = 8'(8'h10 + idx);
                if (in_ready) idx++;
            end else begin
                in_valid = 1'b0;
            end
            cyc++;
        end
        in_valid = 1'b0;
        hold     = 1'b0;
        @(negedge clk);
        check("wrap_finished", cyc < 80, 1);
        check("wrap_emitted", emitted, 10);
        check("wrap_maxcount", maxc <= 4, 1);
        check("wrap_queue", exp_q.size(), 0);

        // Simultaneous push+pop at count 2, then pop-only at full.
        hold     = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h20;
        @(negedge clk);
        in_data  = 8'h21;
        @(negedge clk);
        check("sim_pre_count", count, 2);
        hold    = 1'b0;
        in_data = 8'h22;
        @(negedge clk);
        check("sim_count2", count, 2);
        hold    = 1'b1;
        in_data = 8'h23;
        @(negedge clk);
        in_data = 8'h24;
        @(negedge clk);
        check("sim_count4", count, 4);
        check("sim_full_ready", in_ready, 0);
        hold    = 1'b0;
        in_data = 8'h25;
        @(negedge clk);
        check("sim_full_pop_count", count, 3);
        check("sim_ready_back", in_ready, 1);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("sim_drained", count, 0);
        check("sim_queue", exp_q.size(), 0);

        // Reset mid-stream with count 3 and a strobe in flight.
        hold     = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'(8'h30 + i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        hold     = 1'b0;
        @(negedge clk);
        check("mid_pre_count", count, 3);
        check("mid_pre_out_en", out_en, 1);
        #2;
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_out_en", out_en, 0);
        check("mid_rst_count", count, 0);
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        @(negedge clk);
        in_valid = 1'b0;
        emitted  = 0;
        repeat (3) @(negedge clk);
        check("mid_emitted", emitted, 1);
        check("mid_reg", reg_q, 8'h55);
        check("mid_queue", exp_q.size(), 0);
        check("mid_count", count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
